// File: rtl/rom_loader.sv
// Fills program memory from a framed byte stream (length, 16-bit words, XOR check) and
// holds the CPU in reset until a load completes with a good checksum.
module rom_loader #(
    parameter int ADDR_W    = 15,
    parameter int MAX_WORDS = 32768
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [15:0]       word_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

    state_t            state_q, state_d;
    logic [7:0]        len_hi_q, len_hi_d;
    logic [7:0]        hi_q, hi_d;
    logic [7:0]        csum_q, csum_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [15:0]       word_count_q, word_count_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [15:0]       wr_data_q, wr_data_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic              accept;
    logic [7:0]        csum_nxt;
    logic [15:0]       len_n;
    logic              len_bad;
    logic [16:0]       idx_p1;
    logic              last_word;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            len_hi_q     <= '0;
            hi_q         <= '0;
            csum_q       <= '0;
            idx_q        <= '0;
            word_count_q <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            cpu_reset_q  <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_hi_q     <= len_hi_d;
            hi_q         <= hi_d;
            csum_q       <= csum_d;
            idx_q        <= idx_d;
            word_count_q <= word_count_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            cpu_reset_q  <= cpu_reset_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    always_comb begin
        byte_ready = (state_q == S_LEN_HI)  || (state_q == S_LEN_LO) ||
                     (state_q == S_DATA_HI) || (state_q == S_DATA_LO) ||
                     (state_q == S_CHECK);
        accept    = byte_valid && byte_ready;
        csum_nxt  = csum_q ^ byte_in;
        len_n     = {len_hi_q, byte_in};
        len_bad   = (len_n == 16'd0) || (17'(len_n) > MAX_N);
        // The word being received is the last one when index+1 reaches N.
        idx_p1    = 17'(idx_q) + 17'd1;
        last_word = (idx_p1 == 17'(word_count_q));

        state_d      = state_q;
        len_hi_d     = len_hi_q;
        hi_d         = hi_q;
        csum_d       = csum_q;
        idx_d        = idx_q;
        word_count_d = word_count_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        cpu_reset_d  = cpu_reset_q;
        busy_d       = busy_q;
        done_d       = done_q;
        error_d      = error_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d     = S_LEN_HI;
                    done_d      = 1'b0;
                    error_d     = 1'b0;
                    csum_d      = '0;
                    idx_d       = '0;
                    busy_d      = 1'b1;
                    cpu_reset_d = 1'b1;
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    len_hi_d = byte_in;
                    csum_d   = csum_nxt;
                    state_d  = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    csum_d       = csum_nxt;
                    word_count_d = len_n;
                    if (len_bad) begin
                        state_d = S_ERR;
                        error_d = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = S_DATA_HI;
                    end
                end
            end
            S_DATA_HI: begin
                if (accept) begin
                    hi_d    = byte_in;
                    csum_d  = csum_nxt;
                    state_d = S_DATA_LO;
                end
            end
            S_DATA_LO: begin
                if (accept) begin
                    csum_d    = csum_nxt;
                    wr_en_d   = 1'b1;
                    wr_addr_d = idx_q;
                    wr_data_d = {hi_q, byte_in};
                    idx_d     = idx_q + ADDR_W'(1);
                    state_d   = last_word ? S_CHECK : S_DATA_HI;
                end
            end
            S_CHECK: begin
                if (accept) begin
                    csum_d = csum_nxt;
                    busy_d = 1'b0;
                    if (csum_nxt == 8'h00) begin
                        state_d     = S_DONE;
                        done_d      = 1'b1;
                        cpu_reset_d = 1'b0;
                    end else begin
                        state_d = S_ERR;
                        error_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign cpu_reset  = cpu_reset_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_rom_loader.sv
// Scoreboard bench for rom_loader: expected writes are queued from a frame-level model,
// a negedge monitor pops them whenever wr_en is seen.
module tb_rom_loader;

    localparam int ADDR_W    = 15;
    localparam int MAX_WORDS = 32768;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [15:0]       data;
    } wr_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;
    logic              cpu_reset;
    logic              busy;
    logic              done;
    logic              error;
    logic [15:0]       word_count;

    int  checks   = 0;
    int  failures = 0;
    wr_t exp_q[$];

    rom_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cpu_reset  (cpu_reset),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (wr_en !== 1'b0) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got wr_en=%b addr=%0h data=%0h expected no write",
                         wr_en, wr_addr, wr_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 32'(wr_addr), 32'(e.addr));
                chk("wr_data", 32'(wr_data), 32'(e.data));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input int maxgap);
        int gap;
        int t;
        gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
        repeat (gap) @(posedge clk);
        if (gap > 0) #1;
        byte_in    = b;
        byte_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (byte_ready !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (byte_ready !== 1'b1) begin
            chk("byte_accept_timeout", 32'(byte_ready), 32'd1);
            byte_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            byte_valid = 1'b0;
            byte_in    = 8'($urandom);
        end
    endtask

    task automatic pulse_start(input bit expect_load);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("start_done", 32'(done), 32'd0);
        chk("start_error", 32'(error), 32'd0);
        if (expect_load) chk("start_byte_ready", 32'(byte_ready), 32'd1);
    endtask

    // Frame-level model: decide writes and outcome from the byte list, then drive it.
    task automatic run_frame(input bq_t f, input int maxgap, input int pulse_after);
        logic [15:0] n;
        bit          n_ok;
        logic [7:0]  x;
        int          nbytes;
        wr_t         w;
        n    = {f[0], f[1]};
        n_ok = (n != 0) && (int'(n) <= MAX_WORDS);
        nbytes = n_ok ? 2 * int'(n) + 3 : 2;
        x = 8'h00;
        for (int i = 0; i < nbytes; i++) x = x ^ f[i];
        if (n_ok) begin
            for (int i = 0; i < int'(n); i++) begin
                w.addr = ADDR_W'(i);
                w.data = {f[2 + 2 * i], f[3 + 2 * i]};
                exp_q.push_back(w);
            end
        end
        pulse_start(1'b1);
        for (int i = 0; i < nbytes; i++) begin
            send_byte(f[i], maxgap);
            if (i == pulse_after) begin
                start = 1'b1;
                @(posedge clk);
                #1;
                start = 1'b0;
                chk("midstart_busy", 32'(busy), 32'd1);
                chk("midstart_done", 32'(done), 32'd0);
            end
        end
        @(negedge clk);
        chk("end_done", 32'(done), 32'(n_ok && x == 8'h00));
        chk("end_error", 32'(error), 32'(!(n_ok && x == 8'h00)));
        chk("end_cpu_reset", 32'(cpu_reset), 32'(!(n_ok && x == 8'h00)));
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_word_count", 32'(word_count), 32'(n));
        chk("end_byte_ready", 32'(byte_ready), 32'd0);
        chk("end_pending_writes", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic make_frame(input int n, input bit corrupt, output bq_t f);
        logic [7:0] x;
        logic [7:0] b;
        f = {};
        f.push_back(8'(n >> 8));
        f.push_back(8'(n));
        x = f[0] ^ f[1];
        for (int i = 0; i < 2 * n; i++) begin
            b = 8'($urandom);
            f.push_back(b);
            x = x ^ b;
        end
        if (corrupt) x = x ^ 8'($urandom_range(1, 255));
        f.push_back(x);
    endtask

    initial begin
        bq_t f;
        reset      = 1'b0;
        start      = 1'b0;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        #12;
        chk("rst_byte_ready", 32'(byte_ready), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_word_count", 32'(word_count), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_byte_ready", 32'(byte_ready), 32'd0);

        f = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        run_frame(f, 0, -1);
        f = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h43};
        run_frame(f, 0, -1);
        f = '{8'h00, 8'h00};
        run_frame(f, 0, -1);
        f = '{8'h80, 8'h01};
        run_frame(f, 0, -1);
        f = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        run_frame(f, 5, -1);
        // start while busy must be ignored; then start again from DONE.
        run_frame(f, 2, 1);
        run_frame(f, 0, 4);

        // Reset during DATA_LO of word 1: only word 0 may be written.
        exp_q.push_back('{addr: ADDR_W'(0), data: 16'h1234});
        pulse_start(1'b1);
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        send_byte(8'hAB, 0);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_byte_ready", 32'(byte_ready), 32'd0);
        chk("mid_rst_wr_en", 32'(wr_en), 32'd0);
        chk("mid_rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("mid_rst_wr_data", 32'(wr_data), 32'd0);
        chk("mid_rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_word_count", 32'(word_count), 32'd0);
        chk("mid_rst_pending", 32'(exp_q.size()), 32'd0);
        byte_in    = 8'hCD;
        byte_valid = 1'b1;
        repeat (3) @(negedge clk);
        byte_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        f = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        run_frame(f, 1, -1);

        for (int k = 0; k < 20; k++) begin
            int n;
            n = int'($urandom_range(1, 6));
            if ($urandom_range(0, 9) == 0) begin
                f = {};
                if ($urandom_range(0, 1) == 0) begin
                    f.push_back(8'h00);
                    f.push_back(8'h00);
                end else begin
                    f.push_back(8'($urandom_range(8'h81, 8'hFF)));
                    f.push_back(8'($urandom));
                end
            end else begin
                make_frame(n, $urandom_range(0, 2) == 0, f);
            end
            run_frame(f, int'($urandom_range(0, 5)), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rom_loader.md
Name: rom_loader

Overview:
- Writer side of the instruction ROM: the CPU fetches from program memory, and this block fills it.
- Receives a framed byte stream over a valid/ready handshake, assembles 16-bit instruction words and writes them sequentially from address 0.
- Holds the CPU in reset until a load completes and its checksum verifies.
- Sits between an external byte source (UART/host bridge) and the write port of the program RAM that backs ROM32K.

Parameters:
- ADDR_W, 15, program memory address width (32K words).
- MAX_WORDS, 32768, largest accepted word count; must be ≤ 2^ADDR_W.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset; low clears all state immediately.
- start  input  1  level-sampled request to begin a load.
- byte_in  input  8  stream byte.
- byte_valid  input  1  byte_in is valid.
- byte_ready  output  1  loader accepts a byte this cycle.
- wr_en  output  1  program memory write strobe, one cycle per word.
- wr_addr  output  ADDR_W  program memory write address.
- wr_data  output  16  instruction word.
- cpu_reset  output  1  active-high reset to the CPU.
- busy  output  1  load in progress.
- done  output  1  last load succeeded.
- error  output  1  last load failed.
- word_count  output  16  N latched from the frame header.

Behaviour:
- Reset values: byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_reset=1, busy=0, done=0, error=0, word_count=0, checksum accumulator=0.
- Frame format: LEN_HI, LEN_LO (N = {LEN_HI,LEN_LO}), then 2N data bytes, high byte first, then one CHECK byte.
- Frame is valid when the XOR of every frame byte, including both length bytes and CHECK, equals 0x00.
- States: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, DONE, ERR.
- Byte accept: a byte is accepted on a rising edge with byte_valid=1 and byte_ready=1.
  - byte_ready=1 exactly in LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK (combinational from state).
  - byte_valid gaps stall the FSM indefinitely; there is no timeout.
- IDLE / DONE / ERR with start=1 → LEN_HI next cycle.
  - Same edge: clear done, error, checksum and word index; set busy=1, cpu_reset=1.
  - start is ignored in every other state.
- LEN_HI accept → LEN_LO.
- LEN_LO accept → latch word_count = N.
  - N=0 or N>MAX_WORDS → ERR.
  - Otherwise → DATA_HI.
- DATA_HI accept → hold the high byte, go to DATA_LO.
- DATA_LO accept → go to DATA_HI, or to CHECK when the word just received was index N-1.
  - Next cycle: wr_en=1 for exactly one cycle, wr_addr = word index, wr_data = {high, low}; write latency is one cycle after the low byte is accepted.
  - The word index increments after each write and is ADDR_W wide; N≤MAX_WORDS guarantees no wrap.
- CHECK accept: XOR including the CHECK byte
  - = 0 → DONE: done=1, busy=0, cpu_reset=0 on the next cycle.
  - ≠ 0 → ERR: error=1, busy=0, cpu_reset stays 1.
- cpu_reset is 0 only in DONE; reloading from DONE reasserts it on the start edge.
- Reset asserted mid-load: state returns to IDLE immediately, any pending write is dropped and all outputs take reset values; memory contents already written are not restored.
- done and error are mutually exclusive and never both 1.

Test Plan:
- Valid frame: start, then bytes 00 02 12 34 AB CD 42 with byte_valid held high.
  - Writes (0,0x1234) then (1,0xABCD), each wr_en exactly one cycle.
  - word_count=2; done=1 and cpu_reset=0 the cycle after CHECK accept; error=0.
- Same frame with CHECK=0x43 → both words written; error=1, done=0, cpu_reset stays 1.
- Header 00 00 → ERR right after LEN_LO, no wr_en. Header 80 01 (N=32769) → ERR, word_count=0x8001, no wr_en.
- Valid frame from the first scenario with byte_valid toggled pseudo-randomly (gaps of 0-5 cycles) → identical writes and final outputs; byte_ready low in IDLE/DONE/ERR.
- Drive reset low during DATA_LO of word 1 → all outputs at reset values asynchronously, no further wr_en. After release, start plus a valid frame writes again from address 0.
- start pulsed while busy → no effect. start in DONE → cpu_reset=1 and done=0 on that edge; a new load proceeds normally.
